// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth issue/collect stage
package booth_pkg;

    localparam int OPW             = 8;
    localparam int PW              = 16;
    localparam int MUL_LATENCY_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPW-1:0] m;
        logic [OPW-1:0] q;
    } operand_t;

endpackage

// File: rtl/booth_operand_fifo.sv
// rtl/booth_operand_fifo.sv - circular {m,q} operand buffer with occupancy count
module booth_operand_fifo
    import booth_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  operand_t push_data_i,
    input  logic     pop_i,
    output operand_t pop_data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    operand_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Full excludes a same-cycle pop so the ready path depends on the count only.
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage array needs no reset: only entries counted as occupied are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/booth_issue_ctrl.sv
// rtl/booth_issue_ctrl.sv - launches the Booth multiplier and streams out its products
module booth_issue_ctrl
    import booth_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [OPW-1:0] in_m_i,
    input  logic [OPW-1:0] in_q_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [PW-1:0]  out_p_o,
    output logic           mul_start_o,
    output logic [OPW-1:0] mul_m_o,
    output logic [OPW-1:0] mul_q_o,
    input  logic [PW-1:0]  mul_out_i
);

    localparam int CNTW = $clog2(MUL_LATENCY + 1);

    state_e         state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic           mul_start_q;
    logic [OPW-1:0] mul_m_q;
    logic [OPW-1:0] mul_q_q;
    logic           out_valid_q;
    logic [PW-1:0]  out_p_q;

    operand_t fifo_in;
    operand_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     launch;
    logic     at_latency;
    logic     out_free;
    logic     capture;

    assign fifo_in = '{m: in_m_i, q: in_q_i};

    booth_operand_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (in_valid_i),
        .push_data_i (fifo_in),
        .pop_i       (launch),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign in_ready_o = !fifo_full;

    // Capture only happens after a launch, so stale multiplier output after reset is never presented.
    assign launch     = (state_q == IDLE) && !fifo_empty;
    assign at_latency = (cnt_q == CNTW'(MUL_LATENCY));
    assign out_free   = !out_valid_q || out_ready_i;
    assign capture    = ((state_q == RUN) && at_latency && out_free)
                     || ((state_q == STALL) && out_ready_i);

    // Sequencing: launch, count the multiplier latency, then capture or wait for the consumer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNTW'(1);
                if (at_latency) begin
                    state_d = out_free ? IDLE : STALL;
                end
            end
            STALL: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-cycle start pulse; operands stay put until the next launch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mul_start_q <= 1'b0;
            mul_m_q     <= '0;
            mul_q_q     <= '0;
        end else begin
            mul_start_q <= launch;
            if (launch) begin
                mul_m_q <= fifo_head.m;
                mul_q_q <= fifo_head.q;
            end
        end
    end

    // Output holding register; a capture on the accept edge keeps valid high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_p_q     <= mul_out_i;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_p_o     = out_p_q;
    assign mul_start_o = mul_start_q;
    assign mul_m_o     = mul_m_q;
    assign mul_q_o     = mul_q_q;

endmodule
